wash_step_sequencer: RTL and testbench
======================================

// Module: wash_step_sequencer
// PURPOSE
//  Step scheduler for the washing-machine controller: replaces per-state timer instances with one prescaled down-counter.
//  On start, expands the selected program into an ordered list of steps (fill/wash/drain/rinse/rinse-drain/dry).
//  Presents the active step and remaining time to the main FSM and display, with pause, abort and completion handshakes.
// PARAMETERS
//  TICK_DIV     4   clk cycles per time unit (tick); >=1
//  FILL_T       8   fill step length, ticks; all *_T >=1
//  WASH_T       12  wash step length, ticks
//  DRAIN_T      8   wash-drain step length, ticks
//  RINSE_T      9   rinse step length, ticks
//  RDRAIN_T     15  rinse-drain step length, ticks
//  DRY_T        12  dry step length, ticks
//  WASH_REP     2   fill/wash/drain repetitions
//  RINSE_REP    2   rinse/rinse-drain repetitions
//  TW           8   time width; worst-case program total must fit TW bits
// PORTS
//  clk             in   1    system clock, rising edge
//  rst             in   1    asynchronous, active-low reset
//  start           in   1    program start request, sampled in IDLE only
//  program         in   3    0 cold,1 hot,4 warm: full wash; 2 rinse+dry; 3 dry only; 5-7 invalid
//  pause           in   1    hold request (door open / soap missing); level
//  abort           in   1    cancel running program; level
//  step            out  3    active step: 0 none,1 FILL,2 WASH,3 DRAIN,4 RINSE,5 RDRAIN,6 DRY
//  busy            out  1    program in progress (RUN or PAUSE)
//  paused          out  1    in PAUSE
//  done            out  1    one-cycle pulse on program completion
//  step_remaining  out  TW   ticks left in active step
//  remaining       out  TW   ticks left in whole program (display)
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; step=0, busy=0, paused=0, done=0, step_remaining=0, remaining=0, prescaler=0.
//  States: IDLE, RUN, PAUSE, DONE.
//  Step lists, program latched at start and ignored thereafter:
//   - full wash: (1,2,3) x WASH_REP, then (4,5) x RINSE_REP, then 6.
//   - rinse+dry: (4,5) x RINSE_REP, then 6.
//   - dry only: 6.
//  IDLE: start=1 with valid program -> RUN next edge.
//   - Same edge: busy=1, step=first step, step_remaining=its length, remaining=program total, prescaler=0.
//   - Invalid program or abort=1: start ignored, stay IDLE.
//  RUN: prescaler counts 0..TICK_DIV-1; tick asserted when prescaler==TICK_DIV-1, then wraps to 0.
//   - On tick: remaining decrements (saturates at 0); step_remaining decrements.
//   - Tick with step_remaining==1, not last step: same edge loads next step and its length.
//   - Tick with step_remaining==1, last step: -> DONE.
//   - Step length is exactly *_T*TICK_DIV clk cycles; program length is total*TICK_DIV cycles.
//  PAUSE: entered on edge where RUN sees pause=1 (pause beats a coincident tick; tick is lost, prescaler frozen).
//   - paused=1; prescaler, step, step_remaining and remaining all frozen.
//   - pause=0 -> RUN next edge; prescaler resumes from held value.
//  Abort: abort=1 in RUN/PAUSE -> IDLE next edge.
//   - Clears step, busy, paused, step_remaining, remaining; no done pulse.
//   - Priority: abort > pause > tick.
//  DONE: single cycle with done=1, busy=0, step=0, remaining=0 -> IDLE.
//   - start during DONE ignored; earliest restart is the following cycle.
//  start while busy ignored; program changes mid-run ignored.
//  rst low mid-program returns to reset values immediately; no done.
// TESTING
//  - Dry only, TICK_DIV=4, DRY_T=12: start -> next cycle busy=1, step=6, remaining=12; done pulses 48 cycles after busy rose, then step=0.
//  - Cold wash, defaults: remaining=116 at start; step sequence 1,2,3,1,2,3,4,5,4,5,6; done 464 cycles after start.
//  - Hold pause 10 cycles mid-WASH: paused=1, remaining/step_remaining constant, done delayed exactly 10 cycles vs. no pause.
//  - Assert abort during RINSE: next cycle busy=0, step=0, remaining=0; no done pulse; new start accepted the cycle after.
//  - start with program=5,6,7, or with abort=1: busy stays 0; start during run with other program: sequence unchanged.
//  - Drive rst=0 mid-RDRAIN asynchronously: all outputs 0 before next clk edge; start after release runs normally.

Source files
------------

// File: rtl/wash_step_sequencer_if.sv
// Handshake bundle between the wash step sequencer and the main FSM / display.
// The master drives program requests; the slave (sequencer) reports step and time.
interface wash_step_sequencer_if #(
  parameter int TW = 8
);
  logic          start;
  logic [2:0]    prog;
  logic          pause;
  logic          abort;
  logic [2:0]    step;
  logic          busy;
  logic          paused;
  logic          done;
  logic [TW-1:0] step_remaining;
  logic [TW-1:0] remaining;

  modport master (
    output start, prog, pause, abort,
    input  step, busy, paused, done, step_remaining, remaining
  );

  modport slave (
    input  start, prog, pause, abort,
    output step, busy, paused, done, step_remaining, remaining
  );
endinterface

// File: rtl/wash_step_sequencer.sv
// Washing-machine step scheduler: expands a program into fill/wash/drain/rinse/dry
// steps and times them with a single prescaled down-counter.
module wash_step_sequencer #(
  parameter int TICK_DIV  = 4,
  parameter int FILL_T    = 8,
  parameter int WASH_T    = 12,
  parameter int DRAIN_T   = 8,
  parameter int RINSE_T   = 9,
  parameter int RDRAIN_T  = 15,
  parameter int DRY_T     = 12,
  parameter int WASH_REP  = 2,
  parameter int RINSE_REP = 2,
  parameter int TW        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  wash_step_sequencer_if.slave     bus
);
  localparam int PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RINSE_IDX   = 3 * WASH_REP;
  localparam int DRY_IDX     = RINSE_IDX + 2 * RINSE_REP;
  localparam int IW          = $clog2(DRY_IDX + 2);
  localparam int TOTAL_DRY   = DRY_T;
  localparam int TOTAL_RINSE = RINSE_REP * (RINSE_T + RDRAIN_T) + TOTAL_DRY;
  localparam int TOTAL_FULL  = WASH_REP * (FILL_T + WASH_T + DRAIN_T) + TOTAL_RINSE;
  localparam logic [2:0] STEP_DRY = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  // The full-wash list is the master list; shorter programs start partway into it.
  function automatic logic [2:0] step_at(input logic [IW-1:0] idx);
    int i;
    i = int'(idx);
    if (i < RINSE_IDX) return 3'(i % 3 + 1);
    if (i < DRY_IDX)   return 3'((i - RINSE_IDX) % 2 + 4);
    if (i == DRY_IDX)  return STEP_DRY;
    return 3'd0;
  endfunction

  function automatic logic [TW-1:0] step_len(input logic [2:0] code);
    case (code)
      3'd1:    return TW'(FILL_T);
      3'd2:    return TW'(WASH_T);
      3'd3:    return TW'(DRAIN_T);
      3'd4:    return TW'(RINSE_T);
      3'd5:    return TW'(RDRAIN_T);
      3'd6:    return TW'(DRY_T);
      default: return '0;
    endcase
  endfunction

  function automatic logic prog_valid(input logic [2:0] p);
    return (p <= 3'd4);
  endfunction

  function automatic logic [IW-1:0] first_idx(input logic [2:0] p);
    case (p)
      3'd2:    return IW'(RINSE_IDX);
      3'd3:    return IW'(DRY_IDX);
      default: return '0;
    endcase
  endfunction

  function automatic logic [TW-1:0] prog_total(input logic [2:0] p);
    case (p)
      3'd2:    return TW'(TOTAL_RINSE);
      3'd3:    return TW'(TOTAL_DRY);
      default: return TW'(TOTAL_FULL);
    endcase
  endfunction

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  state_t         state_q;
  logic [IW-1:0]  idx_q;
  logic [PW-1:0]  presc_q;
  logic [2:0]     step_q;
  logic [TW-1:0]  step_rem_q;
  logic [TW-1:0]  rem_q;
  logic           busy_q;
  logic           paused_q;
  logic           done_q;

  logic           tick_d;
  logic [IW-1:0]  idx_d;
  logic [2:0]     next_step_d;
  logic [IW-1:0]  start_idx_d;
  logic [2:0]     start_step_d;

  assign tick_d       = (presc_q == PW'(TICK_DIV - 1));
  assign idx_d        = idx_q + 1'b1;
  assign next_step_d  = step_at(idx_d);
  assign start_idx_d  = first_idx(bus.prog);
  assign start_step_d = step_at(start_idx_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      presc_q    <= '0;
      step_q     <= '0;
      step_rem_q <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      paused_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort && prog_valid(bus.prog)) begin
            state_q    <= S_RUN;
            busy_q     <= 1'b1;
            idx_q      <= start_idx_d;
            step_q     <= start_step_d;
            step_rem_q <= step_len(start_step_d);
            rem_q      <= prog_total(bus.prog);
            presc_q    <= '0;
          end
        end
        // Leaving PAUSE advances on the same edge, so a pause costs exactly its length.
        S_RUN, S_PAUSE: begin
          if (bus.abort) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            paused_q   <= 1'b0;
            step_q     <= '0;
            step_rem_q <= '0;
            rem_q      <= '0;
          end else if (bus.pause) begin
            state_q  <= S_PAUSE;
            paused_q <= 1'b1;
          end else begin
            state_q  <= S_RUN;
            paused_q <= 1'b0;
            if (tick_d) begin
              presc_q <= '0;
              rem_q   <= sat_dec(rem_q);
              if (step_rem_q <= TW'(1)) begin
                if (step_q == STEP_DRY) begin
                  state_q    <= S_DONE;
                  done_q     <= 1'b1;
                  busy_q     <= 1'b0;
                  step_q     <= '0;
                  step_rem_q <= '0;
                  rem_q      <= '0;
                end else begin
                  idx_q      <= idx_d;
                  step_q     <= next_step_d;
                  step_rem_q <= step_len(next_step_d);
                end
              end else begin
                step_rem_q <= sat_dec(step_rem_q);
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.step           = step_q;
  assign bus.busy           = busy_q;
  assign bus.paused         = paused_q;
  assign bus.done           = done_q;
  assign bus.step_remaining = step_rem_q;
  assign bus.remaining      = rem_q;
endmodule

// File: tb/tb_wash_step_sequencer.sv
// Self-checking bench for wash_step_sequencer: directed scenarios plus random stimulus,
// compared every cycle against an elapsed-time reference model.
module tb_wash_step_sequencer;
  localparam int TICK_DIV  = 4;
  localparam int FILL_T    = 8;
  localparam int WASH_T    = 12;
  localparam int DRAIN_T   = 8;
  localparam int RINSE_T   = 9;
  localparam int RDRAIN_T  = 15;
  localparam int DRY_T     = 12;
  localparam int WASH_REP  = 2;
  localparam int RINSE_REP = 2;
  localparam int TW        = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wash_step_sequencer_if #(.TW(TW)) bus ();

  wash_step_sequencer #(
    .TICK_DIV(TICK_DIV), .FILL_T(FILL_T), .WASH_T(WASH_T), .DRAIN_T(DRAIN_T),
    .RINSE_T(RINSE_T), .RDRAIN_T(RDRAIN_T), .DRY_T(DRY_T),
    .WASH_REP(WASH_REP), .RINSE_REP(RINSE_REP), .TW(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a program is a list of steps; progress is the count of
  // un-paused running cycles since start.
  int  codes[$];
  int  m_total;
  int  m_elapsed;
  bit  m_busy, m_paused, m_done, m_in_done;
  int  seq[$];
  int  last_step = 0;

  function automatic int len_of(input int c);
    case (c)
      1: return FILL_T;
      2: return WASH_T;
      3: return DRAIN_T;
      4: return RINSE_T;
      5: return RDRAIN_T;
      6: return DRY_T;
      default: return 0;
    endcase
  endfunction

  function automatic void build(input int p);
    codes.delete();
    if (p == 0 || p == 1 || p == 4)
      repeat (WASH_REP) begin codes.push_back(1); codes.push_back(2); codes.push_back(3); end
    if (p != 3)
      repeat (RINSE_REP) begin codes.push_back(4); codes.push_back(5); end
    codes.push_back(6);
    m_total = 0;
    foreach (codes[k]) m_total += len_of(codes[k]);
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_paused = 0; m_done = 0; m_in_done = 0; m_elapsed = 0;
  endfunction

  function automatic void model_edge();
    if (!rst) begin
      model_reset();
    end else if (m_in_done) begin
      m_in_done = 0; m_done = 0;
    end else if (!m_busy) begin
      if (bus.start && !bus.abort && int'(bus.prog) <= 4) begin
        build(int'(bus.prog));
        m_busy = 1; m_paused = 0; m_elapsed = 0;
      end
    end else if (bus.abort) begin
      m_busy = 0; m_paused = 0;
    end else if (bus.pause) begin
      m_paused = 1;
    end else begin
      m_paused = 0;
      m_elapsed++;
      if (m_elapsed == m_total * TICK_DIV) begin
        m_busy = 0; m_in_done = 1; m_done = 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int e_step, e_srem, e_rem, t, acc;
    bit found;
    e_step = 0; e_srem = 0; e_rem = 0; found = 0; acc = 0;
    if (m_busy) begin
      t = m_elapsed / TICK_DIV;
      foreach (codes[k]) begin
        if (!found && t < acc + len_of(codes[k])) begin
          e_step = codes[k];
          e_srem = acc + len_of(codes[k]) - t;
          found  = 1;
        end
        acc += len_of(codes[k]);
      end
      e_rem = m_total - t;
    end
    chk({tag, ".step"},   32'(bus.step),           32'(e_step));
    chk({tag, ".busy"},   32'(bus.busy),           32'(m_busy));
    chk({tag, ".paused"}, 32'(bus.paused),         32'(m_busy && m_paused));
    chk({tag, ".done"},   32'(bus.done),           32'(m_done));
    chk({tag, ".srem"},   32'(bus.step_remaining), 32'(e_srem));
    chk({tag, ".rem"},    32'(bus.remaining),      32'(e_rem));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_all("cyc");
    if (int'(bus.step) != last_step && bus.step != 3'd0) seq.push_back(int'(bus.step));
    last_step = int'(bus.step);
  endtask

  task automatic wait_step(input int code, input int limit);
    int n;
    n = 0;
    while (bus.step !== 3'(code) && n < limit) begin cycle(); n++; end
    chk("wait_step", 32'(bus.step === 3'(code)), 32'd1);
  endtask

  task automatic wait_done(input int limit, output int at);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < limit) begin cycle(); n++; end
    at = cyc;
    chk("wait_done", 32'(bus.done === 1'b1), 32'd1);
  endtask

  initial begin
    int t0, t1;
    logic [TW-1:0] held_rem, held_srem;
    int exp_seq[11] = '{1, 2, 3, 1, 2, 3, 4, 5, 4, 5, 6};

    bus.start = 0; bus.prog = 3'd0; bus.pause = 0; bus.abort = 0;
    model_reset();

    // Reset state
    #2;
    check_all("reset");
    cycle(); cycle();
    rst = 1'b1;
    cycle();

    // Dry only: 12 ticks x 4 cycles
    bus.prog = 3'd3; bus.start = 1;
    cycle();
    bus.start = 0;
    t0 = cyc;
    chk("dry_step", 32'(bus.step), 32'd6);
    chk("dry_rem",  32'(bus.remaining), 32'd12);
    wait_done(100, t1);
    chk("dry_len", 32'(t1 - t0), 32'd48);
    cycle();

    // Cold full wash, with an ignored start of another program mid-run
    seq.delete();
    bus.prog = 3'd0; bus.start = 1;
    cycle();
    bus.start = 0;
    t0 = cyc;
    chk("cold_rem", 32'(bus.remaining), 32'd116);
    repeat (20) cycle();
    bus.prog = 3'd2; bus.start = 1;
    cycle();
    bus.start = 0;
    wait_done(600, t1);
    chk("cold_len", 32'(t1 - t0), 32'd464);
    chk("cold_nsteps", 32'(seq.size()), 32'd11);
    for (int i = 0; i < 11; i++)
      if (i < seq.size()) chk("cold_seq", 32'(seq[i]), 32'(exp_seq[i]));
    cycle();

    // Warm wash with a 10-cycle pause during WASH
    bus.prog = 3'd4; bus.start = 1;
    cycle();
    bus.start = 0;
    t0 = cyc;
    wait_step(2, 100);
    repeat (3) cycle();
    held_rem = bus.remaining; held_srem = bus.step_remaining;
    bus.pause = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("pause_flag", 32'(bus.paused), 32'd1);
      chk("pause_rem",  32'(bus.remaining), 32'(held_rem));
      chk("pause_srem", 32'(bus.step_remaining), 32'(held_srem));
    end
    bus.pause = 0;
    wait_done(600, t1);
    chk("pause_len", 32'(t1 - t0), 32'd474);
    cycle();

    // Invalid programs and start with abort held
    for (int p = 5; p <= 7; p++) begin
      bus.prog = 3'(p); bus.start = 1;
      cycle();
      chk("invalid_busy", 32'(bus.busy), 32'd0);
    end
    bus.prog = 3'd0; bus.abort = 1;
    cycle();
    chk("abort_start_busy", 32'(bus.busy), 32'd0);
    bus.start = 0; bus.abort = 0;
    cycle();

    // Abort during RINSE, immediate restart, then start during DONE
    bus.prog = 3'd2; bus.start = 1;
    cycle();
    bus.start = 0;
    wait_step(4, 10);
    repeat (5) cycle();
    bus.abort = 1;
    cycle();
    bus.abort = 0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_step", 32'(bus.step), 32'd0);
    chk("abort_rem",  32'(bus.remaining), 32'd0);
    bus.prog = 3'd3; bus.start = 1;
    cycle();
    bus.start = 0;
    chk("restart_busy", 32'(bus.busy), 32'd1);
    wait_done(100, t1);
    bus.start = 1;
    cycle();
    chk("start_in_done", 32'(bus.busy), 32'd0);
    cycle();
    chk("start_after_done", 32'(bus.busy), 32'd1);
    bus.start = 0; bus.abort = 1;
    cycle();
    bus.abort = 0;

    // Asynchronous reset during RDRAIN
    bus.prog = 3'd2; bus.start = 1;
    cycle();
    bus.start = 0;
    wait_step(5, 200);
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    cycle(); cycle();
    rst = 1'b1;
    bus.prog = 3'd3; bus.start = 1;
    cycle();
    bus.start = 0;
    chk("post_rst_busy", 32'(bus.busy), 32'd1);
    wait_done(100, t1);
    cycle();

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 5) == 0);
      bus.prog  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) bus.pause = ~bus.pause;
      bus.abort = ($urandom_range(0, 399) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
